// File: rtl/decoder_buffered.sv
// rtl/decoder_buffered.sv - buffered 3-to-8 decoder with valid/ready FIFO
module decoder_buffered #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2:0]               in_code,
  input  logic                     in_enable,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [7:0]               out_onehot,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Each entry is {enable, code}; the decode happens on the way out.
  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic       push;
  logic       pop;
  logic [3:0] head;

  // Handshake status depends only on the registered count, so no in_* to out_* path exists.
  always_comb begin
    in_ready  = (count_q != FULL_COUNT);
    out_valid = (count_q != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // Control state; reset discards all entries by clearing pointers and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array is left uncleared; stale contents are never visible because count gates them.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_enable, in_code};
  end

  // Decode the head entry; disabled entries and the empty FIFO both present all-zero.
  always_comb begin
    head       = mem_q[rd_ptr_q];
    out_onehot = 8'h00;
    if (out_valid && head[3]) out_onehot = 8'h01 << head[2:0];
  end

  assign count = count_q;

endmodule
